// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: access size encoding,
// controller state constants, the request bundle and the lane helpers.
package dm_port_arbiter_pkg;

  // Access size encoding used on pN_req_size
  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_HW = 2'd1,
    SZ_W  = 2'd2,
    SZ_DW = 2'd3
  } size_e;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // One port's request fields, bundled so the winner can be muxed in one go
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  // Byte enables of an access inside its 8-byte word
  function automatic logic [7:0] calc_be(input logic [1:0] size, input logic [2:0] ofs);
    logic [7:0] be;
    case (size)
      SZ_B:    be = 8'h01 << ofs;
      SZ_HW:   be = 8'h03 << ofs;
      SZ_W:    be = 8'h0F << ofs;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // An access must sit on a multiple of its own size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] ofs);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_HW:   mis = ofs[0];
      SZ_W:    mis = |ofs[1:0];
      default: mis = |ofs;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane placement of one request onto the 64-bit memory word.
module dm_lane_align
  import dm_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] word_addr,
  output logic [7:0]  be,
  output logic [63:0] wdata_sh,
  output logic        misaligned
);

  assign word_addr  = {addr[63:3], 3'b000};
  assign be         = calc_be(size, addr[2:0]);
  assign wdata_sh   = wdata << {addr[2:0], 3'b000};
  assign misaligned = is_misaligned(size, addr[2:0]);

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a single data-memory port. Port 0 (MEM stage)
// has priority, port 1 (loader/debug) is guaranteed a slot after STARVE_MAX
// consecutive port-0 grants. One transaction in flight at a time.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | ready offered to the winning port, waits for a request
//   ST_ISSUE | dm_req held with registered fields until dm_gnt
//   ST_WAIT  | granted, waiting for dm_rvalid or the latency timeout
//   ST_RESP  | one-cycle response pulse to the owning port
//
// STARVE_MAX must be >= 1 and DM_LAT_MAX >= 2.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int DM_LAT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_size,
  input  logic [63:0] p0_req_addr,
  input  logic [63:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [63:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_size,
  input  logic [63:0] p1_req_addr,
  input  logic [63:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [63:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [7:0]  dm_be,
  output logic [63:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [63:0] dm_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(DM_LAT_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // WAIT is entered one cycle after the grant and the response register adds
  // one more, so the down-counter starts two short of the limit.
  localparam logic [LW-1:0] LAT_LOAD = LW'(DM_LAT_MAX - 2);

  logic [1:0]    state_q, state_d;
  logic          owner_q;
  logic [SW-1:0] starve_q;
  logic [LW-1:0] lat_q;

  logic          idle, p1_wins, acc0, acc1, accept;
  req_t          sel;
  logic [63:0]   word_addr, wdata_sh;
  logic [7:0]    be;
  logic          misaligned;

  logic          fire, fire_err, fire_port;
  logic [63:0]   fire_data;

  // Ready is decoded from the registered state so the handshake closes in the
  // same cycle; everything else leaving the block comes straight from flops.
  assign idle         = (state_q == ST_IDLE);
  assign p1_wins      = p1_req_valid && (!p0_req_valid || (starve_q == STARVE_LIM));
  assign p0_req_ready = idle && p0_req_valid && !p1_wins;
  assign p1_req_ready = idle && p1_wins;
  assign acc0         = p0_req_valid && p0_req_ready;
  assign acc1         = p1_req_valid && p1_req_ready;
  assign accept       = acc0 || acc1;

  // Mux the winning port's request fields
  always_comb begin
    sel = '0;
    if (p1_wins) sel = '{we: p1_req_we, size: p1_req_size, addr: p1_req_addr, wdata: p1_req_wdata};
    else         sel = '{we: p0_req_we, size: p0_req_size, addr: p0_req_addr, wdata: p0_req_wdata};
  end

  dm_lane_align u_lane_align (
    .size       (sel.size),
    .addr       (sel.addr),
    .wdata      (sel.wdata),
    .word_addr  (word_addr),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .misaligned (misaligned)
  );

  // Next state plus the response to post when entering ST_RESP
  always_comb begin
    state_d   = state_q;
    fire      = 1'b0;
    fire_err  = 1'b0;
    fire_data = '0;
    fire_port = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fire_port = acc1;
          if (misaligned) begin
            state_d  = ST_RESP;
            fire     = 1'b1;
            fire_err = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (dm_gnt) begin
          if (dm_rvalid) begin
            state_d   = ST_RESP;
            fire      = 1'b1;
            fire_data = dm_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dm_rvalid) begin
          state_d   = ST_RESP;
          fire      = 1'b1;
          fire_data = dm_rdata;
        end else if (lat_q == '0) begin
          state_d  = ST_RESP;
          fire     = 1'b1;
          fire_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and owner of the transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) owner_q <= acc1;
    end
  end

  // Memory request fields, captured on an aligned accept and held until gnt
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
    end else if (accept && !misaligned) begin
      dm_req   <= 1'b1;
      dm_we    <= sel.we;
      dm_addr  <= word_addr;
      dm_be    <= be;
      dm_wdata <= wdata_sh;
    end else if (state_q == ST_ISSUE && dm_gnt) begin
      dm_req <= 1'b0;
    end
  end

  // Grant-to-completion timeout down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q <= '0;
    end else if (state_q == ST_ISSUE && dm_gnt) begin
      lat_q <= LAT_LOAD;
    end else if (state_q == ST_WAIT && !dm_rvalid && lat_q != '0) begin
      lat_q <= lat_q - LW'(1);
    end
  end

  // Consecutive port-0 grants while port 1 keeps waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!p1_req_valid || acc1) begin
      starve_q <= '0;
    end else if (acc0 && starve_q != STARVE_LIM) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // Response pulse to the owning port; rdata holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p1_rsp_err   <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      p0_rsp_valid <= fire && !fire_port;
      p1_rsp_valid <= fire && fire_port;
      p0_rsp_err   <= fire && !fire_port && fire_err;
      p1_rsp_err   <= fire && fire_port && fire_err;
      if (fire && !fire_port) p0_rsp_rdata <= fire_data;
      if (fire && fire_port)  p1_rsp_rdata <= fire_data;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model with cycle timestamps.
module tb_dm_port_arbiter;

  localparam int SMAX = 4;
  localparam int LAT  = 15;

  logic        clk;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [1:0]  p0_req_size;
  logic [63:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [63:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [1:0]  p1_req_size;
  logic [63:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [63:0] p1_rsp_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [7:0]  dm_be;

  dm_port_arbiter #(.STARVE_MAX(SMAX), .DM_LAT_MAX(LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Staged inputs for the next cycle
  logic        n_rst, n_p0v, n_p0we, n_p1v, n_p1we, n_gnt, n_rvalid;
  logic [1:0]  n_p0sz, n_p1sz;
  logic [63:0] n_p0addr, n_p0wdata, n_p1addr, n_p1wdata, n_rdata;
  bit          mem_auto;

  // Model state; cycle numbers index the compare points
  int          t;
  int          m_free_at, m_rsp_cyc, m_gnt_cyc, m_streak;
  bit          m_req_on, m_waiting, m_owner, m_rsp_port, m_rsp_err;
  logic [63:0] m_rsp_data, m_rdata0, m_rdata1;
  logic        m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  bit          e_r0, e_r1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  function automatic bit mdl_mis(input logic [1:0] sz, input logic [63:0] a);
    int nb  = 1 << sz;
    int ofs = int'(a[2:0]);
    return (ofs % nb) != 0;
  endfunction

  function automatic logic [7:0] mdl_be(input logic [1:0] sz, input logic [63:0] a);
    int nb  = 1 << sz;
    int ofs = int'(a[2:0]);
    return 8'(((1 << nb) - 1) << ofs);
  endfunction

  task automatic mdl_reset();
    m_free_at = t + 1; m_rsp_cyc = -1; m_gnt_cyc = 0; m_streak = 0;
    m_req_on = 0; m_waiting = 0; m_owner = 0; m_rsp_port = 0; m_rsp_err = 0;
    m_rsp_data = '0; m_rdata0 = '0; m_rdata1 = '0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
  endtask

  task automatic sched(input bit err, input logic [63:0] data);
    m_rsp_cyc = t + 1; m_rsp_port = m_owner; m_rsp_err = err;
    m_rsp_data = data; m_waiting = 0; m_free_at = t + 2;
  endtask

  task automatic compare();
    bit p1w, free, v0, v1;
    if (t == m_rsp_cyc) begin
      if (m_rsp_port) m_rdata1 = m_rsp_data; else m_rdata0 = m_rsp_data;
    end
    free = (t >= m_free_at);
    p1w  = p1_req_valid && (!p0_req_valid || m_streak == SMAX);
    e_r0 = free && p0_req_valid && !p1w;
    e_r1 = free && p1w;
    v0 = (t == m_rsp_cyc) && !m_rsp_port;
    v1 = (t == m_rsp_cyc) && m_rsp_port;
    chk("p0_req_ready", 64'(p0_req_ready), 64'(e_r0));
    chk("p1_req_ready", 64'(p1_req_ready), 64'(e_r1));
    chk("p0_rsp_valid", 64'(p0_rsp_valid), 64'(v0));
    chk("p1_rsp_valid", 64'(p1_rsp_valid), 64'(v1));
    chk("p0_rsp_err", 64'(p0_rsp_err), 64'(v0 && m_rsp_err));
    chk("p1_rsp_err", 64'(p1_rsp_err), 64'(v1 && m_rsp_err));
    chk("p0_rsp_rdata", p0_rsp_rdata, m_rdata0);
    chk("p1_rsp_rdata", p1_rsp_rdata, m_rdata1);
    chk("dm_req", 64'(dm_req), 64'(m_req_on));
    chk("dm_we", 64'(dm_we), 64'(m_we));
    chk("dm_addr", dm_addr, m_addr);
    chk("dm_be", 64'(dm_be), 64'(m_be));
    chk("dm_wdata", dm_wdata, m_wdata);
  endtask

  // Advance the model by the inputs applied during cycle t
  task automatic mdl_update();
    logic [1:0]  sz;
    logic [63:0] a, wd;
    if (rst) begin
      mdl_reset();
      return;
    end
    if (!p1_req_valid || e_r1) m_streak = 0;
    else if (e_r0 && m_streak < SMAX) m_streak++;
    if (e_r0 || e_r1) begin
      m_owner = e_r1;
      sz = e_r1 ? p1_req_size  : p0_req_size;
      a  = e_r1 ? p1_req_addr  : p0_req_addr;
      wd = e_r1 ? p1_req_wdata : p0_req_wdata;
      if (mdl_mis(sz, a)) begin
        sched(1'b1, '0);
      end else begin
        m_req_on  = 1;
        m_free_at = 32'h7fffffff;
        m_we      = e_r1 ? p1_req_we : p0_req_we;
        m_addr    = a & ~64'h7;
        m_be      = mdl_be(sz, a);
        m_wdata   = wd << (8 * int'(a[2:0]));
      end
    end else if (m_req_on && dm_gnt) begin
      m_req_on = 0;
      if (dm_rvalid) sched(1'b0, dm_rdata);
      else begin m_waiting = 1; m_gnt_cyc = t; end
    end else if (m_waiting) begin
      if (dm_rvalid) sched(1'b0, dm_rdata);
      else if (t + 1 - m_gnt_cyc == LAT) sched(1'b1, '0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = n_rst;
    p0_req_valid = n_p0v; p0_req_we = n_p0we; p0_req_size = n_p0sz;
    p0_req_addr = n_p0addr; p0_req_wdata = n_p0wdata;
    p1_req_valid = n_p1v; p1_req_we = n_p1we; p1_req_size = n_p1sz;
    p1_req_addr = n_p1addr; p1_req_wdata = n_p1wdata;
    if (mem_auto) begin
      dm_gnt    = ($urandom_range(0, 1) == 1);
      dm_rvalid = ($urandom_range(0, 7) == 0);
      if (m_req_on && !dm_gnt) dm_rvalid = 1'b0;
      dm_rdata  = {$urandom, $urandom};
    end else begin
      dm_gnt = n_gnt; dm_rvalid = n_rvalid; dm_rdata = n_rdata;
    end
    @(negedge clk);
    t++;
    compare();
    mdl_update();
  endtask

  task automatic stage_p0(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    n_p0v = 1; n_p0we = we; n_p0sz = sz; n_p0addr = a; n_p0wdata = wd;
  endtask

  task automatic drain();
    n_p0v = 0; n_p1v = 0; n_gnt = 1; n_rvalid = 1;
    repeat (4) cyc();
    n_gnt = 0; n_rvalid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[10];
    int ng, k;
    n_rst = 1; n_p0v = 0; n_p0we = 0; n_p0sz = 0; n_p0addr = 0; n_p0wdata = 0;
    n_p1v = 0; n_p1we = 0; n_p1sz = 0; n_p1addr = 0; n_p1wdata = 0;
    n_gnt = 0; n_rvalid = 0; n_rdata = 0; mem_auto = 0;
    rst = 1; p0_req_valid = 0; p0_req_we = 0; p0_req_size = 0; p0_req_addr = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_size = 0; p1_req_addr = 0; p1_req_wdata = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    t = 0;
    mdl_reset();
    @(posedge clk);
    cyc();
    n_rst = 0;
    cyc();
    chk("reset_dm_be", 64'(dm_be), 64'h0);
    chk("reset_p0_rsp_valid", 64'(p0_rsp_valid), 64'h0);

    // Reset asserted for two cycles while a load sits in WAIT
    stage_p0(0, 2'd2, 64'h100, 0);
    cyc();
    n_p0v = 0;
    cyc();
    n_gnt = 1; cyc();
    n_gnt = 0; cyc(); cyc();
    n_rst = 1; cyc(); cyc();
    n_rst = 0; n_rvalid = 1; n_rdata = 64'h5555_AAAA_5555_AAAA;
    cyc();
    chk("rst_dm_req", 64'(dm_req), 64'h0);
    chk("rst_dm_addr", dm_addr, 64'h0);
    cyc();
    n_rvalid = 0; cyc();
    chk("rst_late_rvalid_no_rsp", 64'(p0_rsp_valid), 64'h0);
    chk("rst_rdata_zero", p0_rsp_rdata, 64'h0);

    // Word store at 0x1004
    stage_p0(1, 2'd2, 64'h1004, 64'hDEADBEEF);
    cyc();
    chk("sw_accept_ready", 64'(p0_req_ready), 64'h1);
    n_p0v = 0; cyc();
    chk("sw_dm_addr", dm_addr, 64'h1000);
    chk("sw_dm_be", 64'(dm_be), 64'hF0);
    chk("sw_dm_wdata", dm_wdata, 64'hDEADBEEF_00000000);
    chk("sw_model_be", 64'(m_be), 64'hF0);
    n_gnt = 1; cyc();
    n_gnt = 0; n_rvalid = 1; n_rdata = 64'hCAFE; cyc();
    n_rvalid = 0; cyc();
    chk("sw_rsp_valid", 64'(p0_rsp_valid), 64'h1);
    cyc();
    chk("sw_rsp_one_pulse", 64'(p0_rsp_valid), 64'h0);

    // Misaligned halfword load at 0x2003
    stage_p0(0, 2'd1, 64'h2003, 0);
    cyc();
    chk("hw_mis_accept", 64'(p0_req_ready), 64'h1);
    cyc();
    chk("hw_mis_no_req", 64'(dm_req), 64'h0);
    chk("hw_mis_err", 64'(p0_rsp_err), 64'h1);
    chk("hw_mis_rdata", p0_rsp_rdata, 64'h0);
    cyc();
    chk("hw_mis_ready_again", 64'(p0_req_ready), 64'h1);
    n_p0v = 0; cyc(); cyc();

    // Both ports continuously valid: four p0 grants then one p1
    stage_p0(0, 2'd2, 64'h4000, 0);
    n_p1v = 1; n_p1we = 0; n_p1sz = 2'd3; n_p1addr = 64'h5000; n_p1wdata = 0;
    n_gnt = 1; n_rvalid = 1; n_rdata = 64'h77;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      cyc();
      if (p0_req_valid && p0_req_ready) begin got[ng] = 0; ng++; end
      else if (p1_req_valid && p1_req_ready) begin got[ng] = 1; ng++; end
    end
    chk("starve_grant_count", 64'(ng), 64'd10);
    for (int i = 0; i < ng; i++) chk($sformatf("starve_grant_%0d", i), 64'(got[i]), 64'((i % 5) == 4));
    drain();

    // Memory grants but never completes
    stage_p0(0, 2'd3, 64'h3000, 0);
    cyc();
    n_p0v = 0; cyc();
    n_gnt = 1; cyc();
    n_gnt = 0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      k++;
      if (p0_rsp_valid) break;
    end
    chk("timeout_latency", 64'(k), 64'(LAT));
    chk("timeout_err", 64'(p0_rsp_err), 64'h1);
    stage_p0(0, 2'd2, 64'h3008, 0);
    cyc();
    chk("timeout_back_idle", 64'(p0_req_ready), 64'h1);
    drain();

    // Byte load at 0x7, gnt and rvalid together
    stage_p0(0, 2'd0, 64'h7, 0);
    cyc();
    n_p0v = 0; n_gnt = 1; n_rvalid = 1; n_rdata = 64'h1122334455667788;
    cyc();
    chk("lb_dm_be", 64'(dm_be), 64'h80);
    chk("lb_dm_req", 64'(dm_req), 64'h1);
    n_gnt = 0; n_rvalid = 0; cyc();
    chk("lb_rsp_valid", 64'(p0_rsp_valid), 64'h1);
    chk("lb_rsp_rdata", p0_rsp_rdata, 64'h1122334455667788);
    cyc();

    // Randomized traffic on both ports with a random memory
    mem_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      n_rst = ($urandom_range(0, 399) == 0);
      n_p0v = ($urandom_range(0, 1) == 1);
      n_p1v = ($urandom_range(0, 2) != 0);
      n_p0we = ($urandom_range(0, 1) == 1);
      n_p1we = ($urandom_range(0, 1) == 1);
      n_p0sz = 2'($urandom_range(0, 3));
      n_p1sz = 2'($urandom_range(0, 3));
      n_p0addr = {$urandom, $urandom};
      n_p1addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) n_p0addr[2:0] = 3'b000;
      if ($urandom_range(0, 1) == 1) n_p1addr[2:0] = 3'b000;
      n_p0wdata = {$urandom, $urandom};
      n_p1wdata = {$urandom, $urandom};
      cyc();
    end
    n_rst = 0; n_p0v = 0; n_p1v = 0;
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
